// File: rtl/led_pattern_gen.sv
// ---------------------------------------------------------------------------
// led_pattern_gen
//
// Board bring-up LED pattern generator. A power-of-two prescaler produces one
// pattern step every 2^DIV_W enabled clock cycles. Four patterns can be
// selected at run time: binary down-count, binary up-count, a bouncing
// one-hot scanner and a PWM "breathe" effect.
//
// Build option:
//   LEDPAT_BREATHE_EN  When defined, BREATHE mode (mode=3) is implemented with
//                      its PWM counter and brightness level. When undefined,
//                      those registers do not exist and mode=3 behaves exactly
//                      like DOWN, including the state clear on mode entry.
//
// Ports:
//   clk     in   system clock from the global buffer
//   resetn  in   asynchronous active-low reset
//   en      in   run enable; when low, prescaler and pattern state hold
//   mode    in   [1:0] pattern select: 0 DOWN, 1 UP, 2 SCAN, 3 BREATHE
//   led     out  [N_LEDS-1:0] registered LED drive, active-high
//   tick    out  single-cycle pulse in the cycle after the pattern advances
// ---------------------------------------------------------------------------
module led_pattern_gen #(
    parameter int unsigned N_LEDS = 4,
    parameter int unsigned DIV_W  = 22,
    parameter int unsigned PWM_W  = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              en,
    input  logic [1:0]        mode,
    output logic [N_LEDS-1:0] led,
    output logic              tick
);

    localparam int unsigned      POS_W      = $clog2(N_LEDS);
    localparam logic [POS_W-1:0] POS_LAST   = POS_W'(N_LEDS - 1);
    localparam logic [POS_W-1:0] POS_PENULT = POS_W'(N_LEDS - 2);

    if (N_LEDS < 2 || N_LEDS > 16) begin : g_bad_n_leds
        $error("led_pattern_gen: N_LEDS must be in 2..16");
    end
    if (DIV_W < 1) begin : g_bad_div_w
        $error("led_pattern_gen: DIV_W must be at least 1");
    end
    if (PWM_W < 1) begin : g_bad_pwm_w
        $error("led_pattern_gen: PWM_W must be at least 1");
    end

    typedef enum logic [1:0] {
        MODE_DOWN    = 2'd0,
        MODE_UP      = 2'd1,
        MODE_SCAN    = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [DIV_W-1:0]  div_ctr, div_ctr_nxt;
    logic [N_LEDS-1:0] pat, pat_nxt;
    logic [N_LEDS-1:0] led_nxt;
    logic [POS_W-1:0]  pos, pos_nxt;
    dir_t              dir, dir_nxt;
    mode_t             mode_q;
    logic              mode_chg;
    logic              tick_int;

`ifdef LEDPAT_BREATHE_EN
    localparam logic [PWM_W-1:0] LVL_MAX    = '1;
    localparam logic [PWM_W-1:0] LVL_PENULT = LVL_MAX - 1'b1;

    logic [PWM_W-1:0] pwm_ctr;
    logic [PWM_W-1:0] lvl, lvl_nxt;
`endif

    // A mode change restarts the prescaler and wins over a coincident tick.
    assign mode_chg = (mode != mode_q);
    assign tick_int = en && (&div_ctr) && !mode_chg;

    always_comb begin
        div_ctr_nxt = div_ctr;
        pat_nxt     = pat;
        pos_nxt     = pos;
        dir_nxt     = dir;
`ifdef LEDPAT_BREATHE_EN
        lvl_nxt     = lvl;
`endif
        if (mode_chg) begin
            div_ctr_nxt = '0;
            pat_nxt     = '0;
            pos_nxt     = '0;
            dir_nxt     = DIR_UP;
`ifdef LEDPAT_BREATHE_EN
            lvl_nxt     = '0;
`endif
        end else begin
            if (en) begin
                div_ctr_nxt = div_ctr + 1'b1;
            end
            if (tick_int) begin
                case (mode_q)
                    MODE_UP: begin
                        pat_nxt = pat + 1'b1;
                    end
                    MODE_SCAN: begin
                        // Reversal steps straight to the neighbour so each
                        // end LED stays lit for exactly one tick period.
                        if (dir == DIR_UP) begin
                            if (pos == POS_LAST) begin
                                dir_nxt = DIR_DOWN;
                                pos_nxt = POS_PENULT;
                            end else begin
                                pos_nxt = pos + 1'b1;
                            end
                        end else begin
                            if (pos == '0) begin
                                dir_nxt = DIR_UP;
                                pos_nxt = POS_W'(1);
                            end else begin
                                pos_nxt = pos - 1'b1;
                            end
                        end
                    end
`ifdef LEDPAT_BREATHE_EN
                    MODE_BREATHE: begin
                        if (dir == DIR_UP) begin
                            if (lvl == LVL_MAX) begin
                                dir_nxt = DIR_DOWN;
                                lvl_nxt = LVL_PENULT;
                            end else begin
                                lvl_nxt = lvl + 1'b1;
                            end
                        end else begin
                            if (lvl == '0) begin
                                dir_nxt = DIR_UP;
                                lvl_nxt = PWM_W'(1);
                            end else begin
                                lvl_nxt = lvl - 1'b1;
                            end
                        end
                    end
`endif
                    default: begin
                        pat_nxt = pat - 1'b1;
                    end
                endcase
            end
        end
    end

    always_comb begin
        led_nxt = pat;
        case (mode_q)
            MODE_SCAN: begin
                led_nxt = N_LEDS'(1) << pos;
            end
`ifdef LEDPAT_BREATHE_EN
            MODE_BREATHE: begin
                led_nxt = {N_LEDS{pwm_ctr < lvl}};
            end
`endif
            default: begin
                led_nxt = pat;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_ctr <= '0;
            pat     <= '0;
            pos     <= '0;
            dir     <= DIR_UP;
            mode_q  <= MODE_DOWN;
            led     <= '0;
            tick    <= 1'b0;
        end else begin
            div_ctr <= div_ctr_nxt;
            pat     <= pat_nxt;
            pos     <= pos_nxt;
            dir     <= dir_nxt;
            mode_q  <= mode_t'(mode);
            led     <= led_nxt;
            tick    <= tick_int;
        end
    end

`ifdef LEDPAT_BREATHE_EN
    // The PWM keeps running while en is low so a paused breathe stays lit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pwm_ctr <= '0;
            lvl     <= '0;
        end else begin
            pwm_ctr <= pwm_ctr + 1'b1;
            lvl     <= lvl_nxt;
        end
    end
`endif

endmodule
